// File: rtl/confreg_responder_if.sv
// confreg_responder_if: data-SRAM-style request/response bus between the CPU
// core (master) and the MMIO responder (slave).
interface confreg_responder_if;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output sram_en, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/confreg_responder.sv
// confreg_responder: MMIO register file behind the core's data-SRAM port.
// Serves LED, SWITCH, TIMER, NUM and SCRATCH inside a 64 KB window selected
// by sram_addr[31:16] == BASE_HI. Read data is registered (1-cycle latency),
// read-first on write cycles, and holds while no request is presented.
// Optional feature macro: TIMER_CMP_EN adds COMPARE at 0x0014 and timer_irq.
module confreg_responder #(
    parameter logic [15:0] BASE_HI    = 16'hbfaf,
    parameter logic [31:0] TIMER_INIT = 32'h0
) (
    input  logic                      clk,
    input  logic                      resetn,
    confreg_responder_if.slave        bus,
    input  logic [15:0]               switch_in,
    output logic [15:0]               led_out,
    output logic [31:0]               num_out
`ifdef TIMER_CMP_EN
    ,
    output logic                      timer_irq
`endif
);

    // Word indices (byte offset >> 2) of the mapped registers.
    localparam logic [13:0] W_LED     = 14'h0000;
    localparam logic [13:0] W_SWITCH  = 14'h0001;
    localparam logic [13:0] W_TIMER   = 14'h0002;
    localparam logic [13:0] W_NUM     = 14'h0003;
    localparam logic [13:0] W_SCRATCH = 14'h0004;
`ifdef TIMER_CMP_EN
    localparam logic [13:0] W_COMPARE = 14'h0005;
`endif

    // Byte i of the result comes from wdata when wen[i], else from old.
    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wen);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return r;
    endfunction

    logic [15:0] sw_meta_q, sw_sync_q;
    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] num_q, num_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_val;
    logic        hit;
    logic        wr;
    logic [13:0] word;
    logic [1:0]  unused_byte_sel;

`ifdef TIMER_CMP_EN
    logic [31:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;
`endif

    assign hit             = bus.sram_en && (bus.sram_addr[31:16] == BASE_HI);
    assign wr              = hit && (bus.sram_wen != 4'b0000);
    assign word            = bus.sram_addr[15:2];
    assign unused_byte_sel = bus.sram_addr[1:0];

    // Read mux: value of the addressed register before this cycle's update.
    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        rd_val = 32'h0;
        if (hit) begin
            case (word)
                W_LED:     rd_val = {16'h0, led_q};
                W_SWITCH:  rd_val = {16'h0, sw_sync_q};
                W_TIMER:   rd_val = timer_q;
                W_NUM:     rd_val = num_q;
                W_SCRATCH: rd_val = scratch_q;
`ifdef TIMER_CMP_EN
                W_COMPARE: rd_val = cmp_q;
`endif
                default:   rd_val = 32'h0;
            endcase
        end
    end

    // Next-state: byte-masked register writes, timer count (write wins), rdata hold.
    always_comb begin
        led_d     = led_q;
        num_d     = num_q;
        scratch_d = scratch_q;
        timer_d   = timer_q + 32'd1;
        rdata_d   = bus.sram_en ? rd_val : rdata_q;
        if (wr) begin
            case (word)
                W_LED: begin
                    led_d[7:0]  = bus.sram_wen[0] ? bus.sram_wdata[7:0]  : led_q[7:0];
                    led_d[15:8] = bus.sram_wen[1] ? bus.sram_wdata[15:8] : led_q[15:8];
                end
                W_TIMER:   timer_d   = byte_merge(timer_q, bus.sram_wdata, bus.sram_wen);
                W_NUM:     num_d     = byte_merge(num_q, bus.sram_wdata, bus.sram_wen);
                W_SCRATCH: scratch_d = byte_merge(scratch_q, bus.sram_wdata, bus.sram_wen);
                default:   ;
            endcase
        end
    end

`ifdef TIMER_CMP_EN
    // Compare register and sticky interrupt; a COMPARE write clears and beats a set.
    always_comb begin
        cmp_d = cmp_q;
        irq_d = irq_q;
        if (wr && (word == W_COMPARE)) begin
            cmp_d = byte_merge(cmp_q, bus.sram_wdata, bus.sram_wen);
            irq_d = 1'b0;
        end else if (timer_q == cmp_q) begin
            irq_d = 1'b1;
        end
    end

    // Compare/irq state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmp_q <= 32'hffff_ffff;
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign timer_irq = irq_q;
`endif

    // Main state registers plus the two-flop switch synchronizer.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta_q <= 16'h0;
            sw_sync_q <= 16'h0;
            led_q     <= 16'h0;
            timer_q   <= TIMER_INIT;
            num_q     <= 32'h0;
            scratch_q <= 32'h0;
            rdata_q   <= 32'h0;
        end else begin
            sw_meta_q <= switch_in;
            sw_sync_q <= sw_meta_q;
            led_q     <= led_d;
            timer_q   <= timer_d;
            num_q     <= num_d;
            scratch_q <= scratch_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.sram_rdata = rdata_q;
    assign led_out        = led_q;
    assign num_out        = num_q;

endmodule

// File: doc/confreg_responder.md
Name: confreg_responder

Overview:
- Responder on the far end of the CPU core's data-SRAM-style interface.
- Decodes a 64 KB MMIO window and serves a small register file: LEDs, switches, free-running timer, numeric display, scratch.
- Uses synchronous-SRAM timing: read data appears one cycle after the request, so the core's MEM stage sees it exactly as it would from data RAM.
- Sits in the SoC next to data RAM; the address-select mux in front of it is out of scope.

Parameters:
- BASE_HI, 16'hbfaf: value required on sram_addr[31:16] for a hit.
- TIMER_INIT, 32'h0: timer value at reset.

Ports:
- clk  in  1  system clock, all state on posedge.
- resetn  in  1  asynchronous active-low reset.
- sram_en  in  1  request valid this cycle.
- sram_wen  in  4  per-byte write enables; 0 = read.
- sram_addr  in  32  byte address; [1:0] ignored.
- sram_wdata  in  32  write data.
- sram_rdata  out  32  read data, registered.
- switch_in  in  16  asynchronous board switches.
- led_out  out  16  LED register.
- num_out  out  32  numeric-display register.
- timer_irq  out  1  present only with TIMER_CMP_EN.

Behaviour:
- Hit = sram_en && sram_addr[31:16]==BASE_HI. Register offset = sram_addr[15:0].
- Register map:
  - 0x0000 LED: RW, bits[15:0]; upper bits read 0.
  - 0x0004 SWITCH: RO, zero-extended.
  - 0x0008 TIMER: RW.
  - 0x000C NUM: RW.
  - 0x0010 SCRATCH: RW.
  - Any other offset, or a miss: reads 0, writes ignored.
- Writes are byte-masked: byte i of the target takes wdata byte i iff wen[i]. Register updates at the request's posedge.
- Reads are read-first. When sram_en=1, sram_rdata <= pre-update value of the addressed register, including on write cycles. When sram_en=0, sram_rdata holds. Latency is exactly 1 cycle. No back-pressure; one request accepted every cycle.
- Switch path: switch_in passes through a 2-flop synchronizer. SWITCH reads return the second flop.
- TIMER increments by 1 every cycle, wrapping 0xffffffff->0.
  - On a TIMER write cycle, the next value = byte-merge(wdata, current+1 is NOT applied) = merge of wdata into the current value. The write wins over increment that cycle; counting resumes from the written value.
- Reset (asynchronous, resetn=0): sram_rdata=0, LED=0, NUM=0, SCRATCH=0, TIMER=TIMER_INIT, synchronizer flops=0.
- Reset deassertion mid-request: the request is dropped; the first post-reset request behaves normally.
- led_out and num_out are driven directly from their registers, so a write is visible the cycle after the request.

Optional Feature:
- TIMER_CMP_EN.
- Defined:
  - Adds COMPARE at 0x0014: RW, byte-masked, reset 32'hffffffff.
  - Adds the timer_irq port.
  - timer_irq (registered) sets the cycle after TIMER==COMPARE.
  - It clears on any write to COMPARE. If set and clear occur in the same cycle, clear wins.
  - Reset value of timer_irq is 0.
- Not defined: 0x0014 behaves as unmapped (reads 0, writes ignored) and the port does not exist.

Test Plan:
- Reset then idle: sram_rdata=0, led_out=0, num_out=0. Read TIMER at cycle N after reset -> value N-1+TIMER_INIT, returned at cycle N+1.
- Write NUM=0x12345678 with wen=4'b1111, then write 0xAABBCCDD with wen=4'b0101, then read NUM -> 0x12BB56DD; num_out matches the cycle after each write.
- Drive switch_in=16'h00f0 and read SWITCH on the next cycle -> 0 (synchronizer delay). Read again 3 cycles later -> 0x000000f0.
- Write SCRATCH=0x11111111 then 0x22222222 on back-to-back cycles (read-first): rdata shows 0 after the first, then 0x11111111. A following read returns 0x22222222.
- Read 0x00000000 with addr[31:16]!=BASE_HI -> rdata 0, and LED is unchanged by a write to that missing address.
- TIMER_CMP_EN: write TIMER=0x10 and COMPARE=0x20 -> timer_irq rises once TIMER reaches 0x20. A write of COMPARE=0xffffffff drops it next cycle.
